cfg_uart_frm: RTL

- Configuration-side serial front end of cbc_dig; sits between the RX_C/TX_C pins and the control state machine.
- Receive path: deserializes three 8N1 bytes into one 24-bit command frame and presents it to control with a ready flag.
- Transmit path: serializes the 16-bit response from control (xset echo, 0x0A5A ack, 0x05A5 nak, eeprom read data) as two bytes back to cfg_mstr.

---
 rtl/cfg_uart_frm.sv | 224 ++++++++++++++++++++++
 1 files changed

// File: rtl/cfg_uart_frm.sv
// Configuration serial front end: 8N1 receiver that assembles 3-byte command frames, and a 2-byte response transmitter.
// Optional inter-byte timeout on partial frames is enabled by defining CFG_FRM_TIMEOUT_EN.
module cfg_uart_frm #(
    parameter int unsigned BAUD_DIV     = 32,
    parameter int unsigned TIMEOUT_BITS = 40
) (
    input  logic        clk,
    input  logic        rst_n,
    input  logic        RX_C,
    output logic        TX_C,
    output logic [23:0] cmd_data,
    output logic        cmd_rdy,
    input  logic        clr_cmd_rdy,
    input  logic [15:0] resp_data,
    input  logic        trmt,
    output logic        tx_busy,
    output logic        tx_done
);

    localparam int unsigned CW = $clog2(BAUD_DIV);
    localparam logic [CW-1:0] BIT_LAST = CW'(BAUD_DIV - 1);
    localparam logic [CW-1:0] HALF_BIT = CW'(BAUD_DIV / 2);

    if (BAUD_DIV < 8 || (BAUD_DIV % 2) != 0 || TIMEOUT_BITS == 0) begin : g_bad_cfg
        $error("cfg_uart_frm: BAUD_DIV must be even and >= 8, TIMEOUT_BITS nonzero");
    end

    typedef enum logic [1:0] {IDLE, START, DATA, STOP} uart_st_e;

    // ---------------- receive path ----------------
    logic          rx_s1, rx_s2, rx_prev;
    uart_st_e      rx_st, rx_nxt;
    logic [CW-1:0] rx_cnt;
    logic [2:0]    rx_bit;
    logic [7:0]    rx_sh;
    logic [1:0]    idx;
    logic [15:0]   frm;
    logic          rx_tick, rx_fall, byte_ok, frm_err, gap_exp;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            rx_s1   <= 1'b1;
            rx_s2   <= 1'b1;
            rx_prev <= 1'b1;
        end else begin
            rx_s1   <= RX_C;
            rx_s2   <= rx_s1;
            rx_prev <= rx_s2;
        end
    end

    assign rx_tick = (rx_cnt == '0);
    assign rx_fall = rx_prev & ~rx_s2;

    always_comb begin
        rx_nxt  = rx_st;
        byte_ok = 1'b0;
        frm_err = 1'b0;
        case (rx_st)
            IDLE:  if (rx_fall) rx_nxt = START;
            START: if (rx_tick) rx_nxt = rx_s2 ? IDLE : DATA;
            DATA:  if (rx_tick && rx_bit == 3'd7) rx_nxt = STOP;
            STOP: begin
                if (rx_tick) begin
                    rx_nxt  = IDLE;
                    byte_ok = rx_s2;
                    frm_err = ~rx_s2;
                end
            end
            default: rx_nxt = IDLE;
        endcase
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) rx_st <= IDLE;
        else        rx_st <= rx_nxt;
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            rx_cnt <= '0;
            rx_bit <= '0;
            rx_sh  <= '0;
        end else begin
            case (rx_st)
                IDLE: if (rx_fall) rx_cnt <= HALF_BIT;
                START: begin
                    if (rx_tick) begin
                        rx_cnt <= BIT_LAST;
                        rx_bit <= '0;
                    end else begin
                        rx_cnt <= rx_cnt - 1'b1;
                    end
                end
                DATA: begin
                    if (rx_tick) begin
                        rx_cnt <= BIT_LAST;
                        rx_sh  <= {rx_s2, rx_sh[7:1]};
                        rx_bit <= rx_bit + 3'd1;
                    end else begin
                        rx_cnt <= rx_cnt - 1'b1;
                    end
                end
                STOP: if (!rx_tick) rx_cnt <= rx_cnt - 1'b1;
                default: rx_cnt <= '0;
            endcase
        end
    end

`ifdef CFG_FRM_TIMEOUT_EN
    localparam int unsigned GAP_MAX = TIMEOUT_BITS * BAUD_DIV;
    localparam int unsigned GW      = $clog2(GAP_MAX + 1);
    logic [GW-1:0] gap;

    // Only idle time between bytes of a partial frame counts toward expiry.
    assign gap_exp = (gap == GW'(GAP_MAX - 1)) && (idx != '0) && (rx_st == IDLE);

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n)                              gap <= '0;
        else if (byte_ok || idx == '0 || gap_exp) gap <= '0;
        else if (rx_st == IDLE)                  gap <= gap + 1'b1;
    end
`else
    assign gap_exp = 1'b0;
`endif

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            idx      <= '0;
            frm      <= '0;
            cmd_data <= '0;
            cmd_rdy  <= 1'b0;
        end else begin
            if (frm_err || gap_exp) begin
                idx <= '0;
            end else if (byte_ok) begin
                if (idx == 2'd2) begin
                    cmd_data <= {frm, rx_sh};
                    idx      <= '0;
                end else begin
                    frm <= {frm[7:0], rx_sh};
                    idx <= idx + 2'd1;
                end
            end
            if (byte_ok && idx == 2'd2) cmd_rdy <= 1'b1;
            else if (clr_cmd_rdy)       cmd_rdy <= 1'b0;
        end
    end

    // ---------------- transmit path ----------------
    uart_st_e      tx_st, tx_nxt;
    logic [CW-1:0] tx_cnt;
    logic [2:0]    tx_bit;
    logic [7:0]    tx_sh, tx_lo;
    logic          tx_sec, tx_tick, tx_fin;

    assign tx_tick = (tx_cnt == '0);
    assign tx_busy = (tx_st != IDLE);

    always_comb begin
        tx_nxt = tx_st;
        tx_fin = 1'b0;
        case (tx_st)
            IDLE:  if (trmt) tx_nxt = START;
            START: if (tx_tick) tx_nxt = DATA;
            DATA:  if (tx_tick && tx_bit == 3'd7) tx_nxt = STOP;
            STOP: begin
                if (tx_tick) begin
                    tx_nxt = tx_sec ? IDLE : START;
                    tx_fin = tx_sec;
                end
            end
            default: tx_nxt = IDLE;
        endcase
    end

    always_comb begin
        TX_C = 1'b1;
        case (tx_st)
            START:   TX_C = 1'b0;
            DATA:    TX_C = tx_sh[0];
            default: TX_C = 1'b1;
        endcase
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) tx_st <= IDLE;
        else        tx_st <= tx_nxt;
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            tx_cnt  <= '0;
            tx_bit  <= '0;
            tx_sh   <= '0;
            tx_lo   <= '0;
            tx_sec  <= 1'b0;
            tx_done <= 1'b0;
        end else begin
            tx_done <= tx_fin;
            if (tx_st == IDLE) begin
                if (trmt) begin
                    tx_sh  <= resp_data[15:8];
                    tx_lo  <= resp_data[7:0];
                    tx_cnt <= BIT_LAST;
                    tx_bit <= '0;
                    tx_sec <= 1'b0;
                end
            end else if (tx_tick) begin
                tx_cnt <= BIT_LAST;
                if (tx_st == DATA) begin
                    tx_sh  <= {1'b0, tx_sh[7:1]};
                    tx_bit <= tx_bit + 3'd1;
                end else if (tx_st == STOP) begin
                    tx_sh  <= tx_lo;
                    tx_sec <= 1'b1;
                end
            end else begin
                tx_cnt <= tx_cnt - 1'b1;
            end
        end
    end

endmodule
